// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register. It owns the PC, issues
// the instruction-memory request and applies the decode controller's decisions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WPCIR,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JR,
  input  logic        DBPS,
  input  logic        SMC,
  input  logic        SMC2,
  input  logic        FIN,
  input  logic [31:0] RSVAL,
  input  logic        IMEM_RDY,
  input  logic [31:0] IMEM_DATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] IFPC,
  output logic [31:0] IDPC,
  output logic [31:0] IDIR,
  output logic        IDVALID,
  output logic        HALTED
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state;
  logic        req_q;
  logic        halted_q;
  logic [31:0] pc_p0;
  logic [31:0] idpc_p1;
  logic [31:0] idir_p1;
  logic        vld_p1;
  logic [31:0] target;

  // Redirect target for the instruction currently in ID. DBPS only matters
  // for conditional branches; jr wins over j/jal.
  function automatic logic [31:0] redirect_target(
    input logic        jump,
    input logic        jr,
    input logic        dbps,
    input logic [31:0] idpc,
    input logic [31:0] idir,
    input logic [31:0] rsval
  );
    logic        [31:0] pcp4;
    logic signed [31:0] offset;
    pcp4   = idpc + 32'd4;
    offset = {{14{idir[15]}}, idir[15:0], 2'b00};
    if (jr)
      return rsval;
    else if (jump)
      return {pcp4[31:28], idir[25:0], 2'b00};
    else if (dbps)
      return pcp4 + $unsigned(offset);
    else
      return pcp4;
  endfunction

  assign target = redirect_target(JUMP, JR, DBPS, idpc_p1, idir_p1, RSVAL);

  // Stage p0 (IF): PC and memory request; stage p1 (ID): IF/ID register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RUN;
      req_q    <= 1'b1;
      halted_q <= 1'b0;
      pc_p0    <= RESET_PC;
      idpc_p1  <= RESET_PC;
      idir_p1  <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else if (state == S_HALT) begin
      state <= S_HALT;
    end else if (FIN) begin
      state    <= S_HALT;
      req_q    <= 1'b0;
      halted_q <= 1'b1;
      idir_p1  <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else if (SMC) begin
      // A store overwrote the instruction in ID: refetch it, even under stall.
      pc_p0   <= idpc_p1;
      idir_p1 <= NOP_WORD;
      vld_p1  <= 1'b0;
    end else if (WPCIR) begin
      pc_p0 <= pc_p0;
    end else if (BRANCH) begin
      pc_p0   <= target;
      idir_p1 <= NOP_WORD;
      vld_p1  <= 1'b0;
    end else if (SMC2) begin
      idir_p1 <= NOP_WORD;
      vld_p1  <= 1'b0;
    end else if (IMEM_RDY) begin
      pc_p0   <= pc_p0 + 32'd4;
      idpc_p1 <= pc_p0;
      idir_p1 <= IMEM_DATA;
      vld_p1  <= 1'b1;
    end else begin
      idir_p1 <= NOP_WORD;
      vld_p1  <= 1'b0;
    end
  end

  assign IMEM_REQ  = req_q;
  assign HALTED    = halted_q;
  assign IMEM_ADDR = pc_p0;
  assign IFPC      = pc_p0;
  assign IDPC      = idpc_p1;
  assign IDIR      = idir_p1;
  assign IDVALID   = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: each row is one clock of
// controller/memory inputs and the IF/ID state expected after that edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0, wpcir = 1'b0, branch = 1'b0, jump = 1'b0, jr = 1'b0;
  logic        dbps = 1'b0, smc = 1'b0, smc2 = 1'b0, fin = 1'b0, imem_rdy = 1'b0;
  logic [31:0] rsval = '0, imem_data = '0;
  logic        imem_req, idvalid, halted;
  logic [31:0] imem_addr, ifpc, idpc, idir;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .CLK(clk), .RST(rst), .WPCIR(wpcir), .BRANCH(branch), .JUMP(jump), .JR(jr),
    .DBPS(dbps), .SMC(smc), .SMC2(smc2), .FIN(fin), .RSVAL(rsval),
    .IMEM_RDY(imem_rdy), .IMEM_DATA(imem_data), .IMEM_REQ(imem_req),
    .IMEM_ADDR(imem_addr), .IFPC(ifpc), .IDPC(idpc), .IDIR(idir),
    .IDVALID(idvalid), .HALTED(halted)
  );

  always #5 clk = ~clk;

  // Control bit masks: {rst,wpcir,branch,jump,jr,dbps,smc,smc2,fin}
  localparam logic [8:0] C_RST = 9'h100, C_WP = 9'h080, C_BR = 9'h040, C_J = 9'h020;
  localparam logic [8:0] C_JR = 9'h010, C_DB = 9'h008, C_SMC = 9'h004, C_SMC2 = 9'h002;
  localparam logic [8:0] C_FIN = 9'h001, C_NONE = 9'h000;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] WA = 32'h2001_0001, WB = 32'h2002_0002, WC = 32'h2003_0003;
  localparam logic [31:0] WD = 32'h1000_FFFE, WJ = 32'h0800_0040, WE = 32'h2004_0004;
  localparam logic [31:0] WF = 32'h2005_0005, JUNK = 32'hDEAD_BEEF;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [31:0] rsval;
    logic        rdy;
    logic [31:0] data;
    logic [31:0] e_ifpc;
    logic [31:0] e_idpc;
    logic [31:0] e_idir;
    logic        e_vld;
    logic        e_halt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm, logic [8:0] ctl, logic [31:0] rs, logic rdy,
                              logic [31:0] data, logic [31:0] e_ifpc, logic [31:0] e_idpc,
                              logic [31:0] e_idir, logic e_vld, logic e_halt);
    vec_t v;
    v.name = nm; v.ctl = ctl; v.rsval = rs; v.rdy = rdy; v.data = data;
    v.e_ifpc = e_ifpc; v.e_idpc = e_idpc; v.e_idir = e_idir; v.e_vld = e_vld; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [8:0] ctl, logic [31:0] rs, logic rdy, logic [31:0] data);
    @(negedge clk);
    {rst, wpcir, branch, jump, jr, dbps, smc, smc2, fin} = ctl;
    rsval = rs; imem_rdy = rdy; imem_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(string nm, logic [31:0] e_ifpc, logic [31:0] e_idpc,
                             logic [31:0] e_idir, logic e_vld, logic e_halt);
    chk({nm, ".ifpc"}, ifpc, e_ifpc);
    chk({nm, ".addr"}, imem_addr, e_ifpc);
    chk({nm, ".idpc"}, idpc, e_idpc);
    chk({nm, ".idir"}, idir, e_idir);
    chk({nm, ".idvalid"}, {31'b0, idvalid}, {31'b0, e_vld});
    chk({nm, ".halted"}, {31'b0, halted}, {31'b0, e_halt});
    chk({nm, ".req"}, {31'b0, imem_req}, {31'b0, ~e_halt});
  endtask

  initial begin
    //            name        ctl                    rsval         rdy data   ifpc          idpc          idir  vld halt
    vt.push_back(mk("reset",   C_RST,                 0,            0, JUNK, 32'h0,        32'h0,        NOP,  0, 0));
    vt.push_back(mk("fetchA",  C_NONE,                0,            1, WA,   32'h4,        32'h0,        WA,   1, 0));
    vt.push_back(mk("fetchB",  C_NONE,                0,            1, WB,   32'h8,        32'h4,        WB,   1, 0));
    vt.push_back(mk("stall1",  C_WP,                  0,            1, WC,   32'h8,        32'h4,        WB,   1, 0));
    vt.push_back(mk("stall2",  C_WP,                  0,            1, WC,   32'h8,        32'h4,        WB,   1, 0));
    vt.push_back(mk("fetchC",  C_NONE,                0,            1, WC,   32'hC,        32'h8,        WC,   1, 0));
    vt.push_back(mk("wait1",   C_NONE,                0,            0, JUNK, 32'hC,        32'h8,        NOP,  0, 0));
    vt.push_back(mk("wait2",   C_NONE,                0,            0, JUNK, 32'hC,        32'h8,        NOP,  0, 0));
    vt.push_back(mk("wait3",   C_NONE,                0,            0, JUNK, 32'hC,        32'h8,        NOP,  0, 0));
    vt.push_back(mk("jr_wait", C_BR | C_JR,           32'h10,       0, JUNK, 32'h10,       32'h8,        NOP,  0, 0));
    vt.push_back(mk("fetchD",  C_NONE,                0,            1, WD,   32'h14,       32'h10,       WD,   1, 0));
    // PCp4 0x14 + (0xFFFE sign-extended << 2 = -8) = 0xC
    vt.push_back(mk("br_tkn",  C_BR | C_DB,           0,            1, JUNK, 32'hC,        32'h10,       NOP,  0, 0));
    vt.push_back(mk("fetchD2", C_NONE,                0,            1, WD,   32'h10,       32'hC,        WD,   1, 0));
    vt.push_back(mk("br_nt",   C_BR,                  0,            1, JUNK, 32'h10,       32'hC,        NOP,  0, 0));
    vt.push_back(mk("jr200",   C_BR | C_JR,           32'h200,      1, JUNK, 32'h200,      32'hC,        NOP,  0, 0));
    vt.push_back(mk("jr4000",  C_BR | C_JR | C_DB,    32'h4000_0000,1, JUNK, 32'h4000_0000,32'hC,        NOP,  0, 0));
    vt.push_back(mk("fetchJ",  C_NONE,                0,            1, WJ,   32'h4000_0004,32'h4000_0000,WJ,   1, 0));
    vt.push_back(mk("jump",    C_BR | C_J | C_DB,     0,            1, JUNK, 32'h4000_0100,32'h4000_0000,NOP,  0, 0));
    vt.push_back(mk("j_nobr",  C_J | C_JR,            32'h300,      1, WE,   32'h4000_0104,32'h4000_0100,WE,   1, 0));
    vt.push_back(mk("smc_wp",  C_SMC | C_WP,          0,            1, JUNK, 32'h4000_0100,32'h4000_0100,NOP,  0, 0));
    vt.push_back(mk("refetch", C_NONE,                0,            1, WE,   32'h4000_0104,32'h4000_0100,WE,   1, 0));
    vt.push_back(mk("smc2",    C_SMC2,                0,            1, JUNK, 32'h4000_0104,32'h4000_0100,NOP,  0, 0));
    vt.push_back(mk("fetchF",  C_NONE,                0,            1, WF,   32'h4000_0108,32'h4000_0104,WF,   1, 0));
    vt.push_back(mk("fin",     C_FIN,                 0,            1, JUNK, 32'h4000_0108,32'h4000_0104,NOP,  0, 1));
    vt.push_back(mk("hlt_br",  C_BR | C_JR,           32'h0,        1, WA,   32'h4000_0108,32'h4000_0104,NOP,  0, 1));
    vt.push_back(mk("hlt_rdy", C_NONE,                0,            1, WA,   32'h4000_0108,32'h4000_0104,NOP,  0, 1));
    vt.push_back(mk("hlt_rst", C_RST,                 0,            1, WA,   32'h0,        32'h0,        NOP,  0, 0));
    vt.push_back(mk("fetchA2", C_NONE,                0,            1, WA,   32'h4,        32'h0,        WA,   1, 0));
    vt.push_back(mk("stall3",  C_WP,                  0,            1, WB,   32'h4,        32'h0,        WA,   1, 0));
    vt.push_back(mk("rst_stl", C_RST | C_WP,          0,            1, WB,   32'h0,        32'h0,        NOP,  0, 0));
    vt.push_back(mk("jr_top",  C_BR | C_JR,           32'hFFFF_FFFC,1, JUNK, 32'hFFFF_FFFC,32'h0,        NOP,  0, 0));
    vt.push_back(mk("wrap",    C_NONE,                0,            1, WB,   32'h0,        32'hFFFF_FFFC,WB,   1, 0));

    foreach (vt[i]) begin
      drive(vt[i].ctl, vt[i].rsval, vt[i].rdy, vt[i].data);
      check_state(vt[i].name, vt[i].e_ifpc, vt[i].e_idpc, vt[i].e_idir, vt[i].e_vld, vt[i].e_halt);
    end

    // Reset output values must already be visible right after the edge.
    drive(C_RST, 0, 0, JUNK);
    chk("rst.ifpc_direct", ifpc, 32'h0);

    // Reset in the middle of a memory wait, then halt under random traffic.
    drive(C_NONE, 0, 1, WA);
    drive(C_NONE, 0, 0, JUNK);
    drive(C_RST, 0, 0, JUNK);
    check_state("rst_wait", 32'h0, 32'h0, NOP, 1'b0, 1'b0);
    drive(C_NONE, 0, 1, WA);
    drive(C_FIN | C_SMC | C_BR, 32'h80, 1, WB);
    check_state("fin_pri", 32'h4, 32'h0, NOP, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(9'($urandom_range(0, 9'h0FF)), $urandom, 1'($urandom), $urandom);
      check_state($sformatf("halt_hold%0d", k), 32'h4, 32'h0, NOP, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
